// File: rtl/digit_frame_buffer.sv
// digit_frame_buffer: ping-pong buffer for 28x28 pixel frames.
// A pixel stream fills the write bank while the classifier reads the other bank.
// The classifier releases a frame by writing 0 to its input_valid flag.
// Optional macro DIGIT_FRAME_BUFFER_FRAME_COUNT_EN adds the frames_done release counter.
module digit_frame_buffer #(
    parameter int unsigned NUM_PIXELS = 784,
    parameter int unsigned ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        pix_data,
    input  logic              pix_valid,
    input  logic              pix_last,
    output logic              pix_ready,
    output logic [7:0]        classifier_input_valid_read_data,
    input  logic              classifier_input_valid_write_en,
    input  logic [7:0]        classifier_input_valid_write_data,
    input  logic [ADDR_W-1:0] classifier_input_address_a,
    output logic [15:0]       classifier_input_read_data_a,
    output logic              frame_err
`ifdef DIGIT_FRAME_BUFFER_FRAME_COUNT_EN
    ,
    output logic [15:0]       frames_done
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    logic [7:0]        mem [2][NUM_PIXELS];

    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        full_cnt_q, full_cnt_d;
    logic              frame_err_q, frame_err_d;
    logic [7:0]        rd_data_q, rd_data_d;

    logic accept;
    logic at_last_addr;
    logic commit;
    logic misalign;
    logic release_frame;

    // Handshake and frame-boundary decode for the current cycle.
    always_comb begin
        at_last_addr  = (wr_addr_q == LAST_ADDR);
        accept        = pix_valid && (full_cnt_q != 2'd2);
        commit        = accept && pix_last && at_last_addr;
        misalign      = accept && (pix_last != at_last_addr);
        release_frame = classifier_input_valid_write_en
                        && !classifier_input_valid_write_data[0]
                        && (full_cnt_q != 2'd0);
    end

    // Next-state for write pointer, bank pointers, occupancy and error flag.
    always_comb begin
        wr_addr_d   = wr_addr_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        full_cnt_d  = full_cnt_q;
        frame_err_d = frame_err_q;

        if (accept) begin
            if (pix_last || at_last_addr) begin
                wr_addr_d = '0;
            end else begin
                wr_addr_d = wr_addr_q + ADDR_W'(1);
            end
        end
        if (misalign) begin
            frame_err_d = 1'b1;
        end
        if (commit) begin
            wr_bank_d = ~wr_bank_q;
        end
        if (release_frame) begin
            rd_bank_d = ~rd_bank_q;
        end

        // Simultaneous commit and release cancel out in the occupancy count.
        unique case ({commit, release_frame})
            2'b10:   full_cnt_d = full_cnt_q + 2'd1;
            2'b01:   full_cnt_d = full_cnt_q - 2'd1;
            default: full_cnt_d = full_cnt_q;
        endcase
    end

    // Read-port lookup; out-of-range addresses return zero.
    always_comb begin
        rd_data_d = '0;
        if (classifier_input_address_a <= LAST_ADDR) begin
            rd_data_d = mem[rd_bank_q][classifier_input_address_a];
        end
    end

    // Pixel RAM write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_bank_q][wr_addr_q] <= pix_data;
        end
    end

    // Control state and registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr_q   <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_cnt_q  <= '0;
            frame_err_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            wr_addr_q   <= wr_addr_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_cnt_q  <= full_cnt_d;
            frame_err_q <= frame_err_d;
            rd_data_q   <= rd_data_d;
        end
    end

`ifdef DIGIT_FRAME_BUFFER_FRAME_COUNT_EN
    logic [15:0] frames_done_q, frames_done_d;

    // Count released frames, wrapping naturally at 16 bits.
    always_comb begin
        frames_done_d = frames_done_q;
        if (release_frame) begin
            frames_done_d = frames_done_q + 16'd1;
        end
    end

    // Release counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            frames_done_q <= '0;
        end else begin
            frames_done_q <= frames_done_d;
        end
    end

    assign frames_done = frames_done_q;
`endif

    assign pix_ready                        = (full_cnt_q != 2'd2);
    assign classifier_input_valid_read_data = {7'b0, (full_cnt_q != 2'd0)};
    assign classifier_input_read_data_a     = {8'b0, rd_data_q};
    assign frame_err                        = frame_err_q;

endmodule

// File: tb/tb_digit_frame_buffer.sv
// Testbench for digit_frame_buffer: random pixel stream, releases and reads,
// checked against a frame-queue reference model with a read-data scoreboard.
module tb_digit_frame_buffer;

    localparam int unsigned N  = 784;
    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    pix_data = '0;
    logic          pix_valid = 1'b0;
    logic          pix_last = 1'b0;
    logic          pix_ready;
    logic [7:0]    iv_rd;
    logic          iv_we = 1'b0;
    logic [7:0]    iv_wd = '0;
    logic [AW-1:0] addr_a = '0;
    logic [15:0]   rd_a;
    logic          frame_err;
`ifdef DIGIT_FRAME_BUFFER_FRAME_COUNT_EN
    logic [15:0]   frames_done;
`endif

    always #5 clk = ~clk;

    digit_frame_buffer #(.NUM_PIXELS(N), .ADDR_W(AW)) dut (
        .clk                               (clk),
        .reset                             (reset),
        .pix_data                          (pix_data),
        .pix_valid                         (pix_valid),
        .pix_last                          (pix_last),
        .pix_ready                         (pix_ready),
        .classifier_input_valid_read_data  (iv_rd),
        .classifier_input_valid_write_en   (iv_we),
        .classifier_input_valid_write_data (iv_wd),
        .classifier_input_address_a        (addr_a),
        .classifier_input_read_data_a      (rd_a),
        .frame_err                         (frame_err)
`ifdef DIGIT_FRAME_BUFFER_FRAME_COUNT_EN
        ,
        .frames_done                       (frames_done)
`endif
    );

    int unsigned checks = 0;
    int unsigned fails  = 0;

    // Reference model: committed frames are a FIFO of seeds; pixel values are
    // a pure function of (seed, address).
    int unsigned seeds_q[$];
    int unsigned cur_cnt  = 0;
    int unsigned cur_seed = 0;
    int unsigned next_seed = 1;
    bit          err_m = 1'b0;
    logic [15:0] fd_m = '0;

    logic [15:0] exp_rd_q[$];
    logic        rd_issue = 1'b0;
    logic        rd_out_valid = 1'b0;

    int unsigned stalls_seen = 0;
    int unsigned coincide_seen = 0;

    function automatic logic [7:0] pix_of(input int unsigned seed, input int unsigned a);
        int unsigned v;
        v = a + seed * 37 + ((seed * a) >> 2);
        return v[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Read data appears one cycle after the address is sampled.
    always @(posedge clk) rd_out_valid <= rd_issue;

    // Scoreboard monitor: pops one expectation per presented read result.
    always @(negedge clk) begin
        if (rd_out_valid) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL rd_scoreboard: got %0h with no expectation queued", rd_a);
            end else begin
                check("read_data_a", {16'h0, rd_a}, {16'h0, exp_rd_q.pop_front()});
            end
        end
    end

    task automatic check_status();
        check("pix_ready", {31'h0, pix_ready}, {31'h0, (seeds_q.size() < 2)});
        check("frame_available", {24'h0, iv_rd}, {31'h0, (seeds_q.size() != 0)});
        check("frame_err", {31'h0, frame_err}, {31'h0, err_m});
`ifdef DIGIT_FRAME_BUFFER_FRAME_COUNT_EN
        check("frames_done", {16'h0, frames_done}, {16'h0, fd_m});
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pix_valid = 1'b0;
        pix_last = 1'b0;
        iv_we = 1'b0;
        rd_issue = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        seeds_q.delete();
        cur_cnt = 0;
        cur_seed = next_seed;
        next_seed++;
        err_m = 1'b0;
        fd_m = '0;
        check("read_data_after_reset", {16'h0, rd_a}, 32'h0);
        check_status();
    endtask

    // One clock of stimulus: check state, drive inputs, advance the model.
    task automatic step(input int unsigned valid_pct, input int unsigned rel_div, input bit force_err);
        int unsigned sz;
        bit          acc;
        bit          rel;
        bit          want_last;
        int unsigned a;

        check_status();
        sz = seeds_q.size();

        pix_valid = ($urandom_range(99) < valid_pct);
        want_last = (cur_cnt == N - 1);
        if (force_err && ($urandom_range(1999) == 0)) want_last = 1'b1;
        if (force_err && (cur_cnt == N - 1) && ($urandom_range(19) == 0)) want_last = 1'b0;
        pix_last = want_last;
        pix_data = pix_of(cur_seed, cur_cnt);

        iv_we = (rel_div != 0) && ($urandom_range(rel_div - 1) == 0);
        iv_wd = 8'($urandom);
        // Aim some releases at the cycle that commits the next frame.
        if (sz == 1 && pix_valid && cur_cnt == N - 1 && want_last && $urandom_range(1) == 0) begin
            iv_we = 1'b1;
            iv_wd = 8'h00;
        end

        a = $urandom_range(1023);
        if ($urandom_range(3) == 0) a = $urandom_range(N - 1);
        addr_a = AW'(a);
        rd_issue = 1'b1;
        if (a >= N) exp_rd_q.push_back(16'h0000);
        else if (sz != 0) exp_rd_q.push_back({8'h00, pix_of(seeds_q[0], a)});
        else rd_issue = 1'b0;

        acc = pix_valid && (sz < 2);
        rel = iv_we && !iv_wd[0] && (sz != 0);
        if (pix_valid && sz == 2) stalls_seen++;
        if (rel) begin
            void'(seeds_q.pop_front());
            fd_m = fd_m + 16'd1;
        end
        if (acc) begin
            if (want_last && cur_cnt == N - 1) begin
                if (rel) coincide_seen++;
                seeds_q.push_back(cur_seed);
                cur_seed = next_seed;
                next_seed++;
                cur_cnt = 0;
            end else if (want_last || cur_cnt == N - 1) begin
                err_m = 1'b1;
                cur_seed = next_seed;
                next_seed++;
                cur_cnt = 0;
            end else begin
                cur_cnt++;
            end
        end

        @(posedge clk);
        #1;
    endtask

    initial begin
        bit did_reset;
        did_reset = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        // First frame uses seed 0, i.e. pixel value = address[7:0].
        cur_seed = 0;
        // Fill without releases so the buffer saturates and stalls the third frame.
        for (int i = 0; i < 2700; i++) step(100, 0, 1'b0);
        // Releases only when explicitly requested with bit0 set to 0.
        iv_we = 1'b1;
        iv_wd = 8'h01;
        for (int i = 0; i < 20; i++) step(0, 0, 1'b0);
        // Main random phase with varying release rates and alignment errors.
        for (int i = 0; i < 24000; i++) begin
            if (!did_reset && i > 12000 && seeds_q.size() == 1 && cur_cnt >= 400) begin
                do_reset();
                did_reset = 1'b1;
            end
            step(85, (i < 12000) ? 600 : 900, 1'b1);
        end
        pix_valid = 1'b0;
        iv_we = 1'b0;
        rd_issue = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (stalls_seen == 0) $display("note: no stall cycles occurred");
        if (coincide_seen == 0) $display("note: no commit/release coincidence occurred");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/digit_frame_buffer.md
DIGIT_FRAME_BUFFER -- requirements
Module: digit_frame_buffer

Interface
REQ-001 Parameter: NUM_PIXELS, 784, pixels per frame (28x28 digit).
REQ-002 Parameter: ADDR_W, 10, pixel address width; 2^ADDR_W >= NUM_PIXELS.
REQ-003 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: pix_data  input  8  upstream pixel value.
REQ-006 Port: pix_valid  input  1  upstream pixel present.
REQ-007 Port: pix_last  input  1  marks final pixel of a frame.
REQ-008 Port: pix_ready  output  1  buffer accepts pixel this cycle.
REQ-009 Port: classifier_input_valid_read_data  output  8  {7'b0, frame_available}.
REQ-010 Port: classifier_input_valid_write_en  input  1  classifier writes its input_valid flag.
REQ-011 Port: classifier_input_valid_write_data  input  8  value written; bit 0 only is significant.
REQ-012 Port: classifier_input_address_a  input  ADDR_W  pixel read address.
REQ-013 Port: classifier_input_read_data_a  output  16  {8'b0, pixel}, registered.
REQ-014 Port: frame_err  output  1  sticky frame-alignment error.

Function
REQ-015 Storage SHALL be two banks of NUM_PIXELS x 8 bits (ping-pong); wr_bank, rd_bank pointers and full_cnt (0..2) track state.
REQ-016 pix_ready SHALL be 1 iff full_cnt < 2; a pixel is accepted when pix_valid && pix_ready.
REQ-017 Accepted pixel SHALL be written to wr_bank[wr_addr]; wr_addr increments by 1.
REQ-018 Accepted pixel with pix_last=1 and wr_addr==NUM_PIXELS-1 SHALL commit the frame: wr_addr<=0, wr_bank toggles, full_cnt+1.
REQ-019 Accepted pixel where pix_last and (wr_addr==NUM_PIXELS-1) disagree SHALL set frame_err, discard the partial frame (wr_addr<=0, no commit, no bank toggle).
REQ-020 frame_available SHALL equal (full_cnt != 0), with no combinational path from pixel inputs.
REQ-021 write_en with write_data[0]==0 and full_cnt!=0 SHALL release rd_bank: rd_bank toggles, full_cnt-1.
REQ-022 write_en with write_data[0]==1, or with full_cnt==0, SHALL be ignored.
REQ-023 Commit and release in the same cycle SHALL leave full_cnt unchanged while both pointers toggle.
REQ-024 read_data_a SHALL be {8'b0, rd_bank[address_a]} registered, 1-cycle latency; address_a >= NUM_PIXELS returns 16'h0000.
REQ-025 Reads SHALL always target rd_bank regardless of full_cnt; write bank and read bank never alias while full_cnt != 0.

Reset
REQ-026 Reset SHALL clear wr_addr, wr_bank, rd_bank, full_cnt, frame_err, read_data_a to 0; pix_ready=1, frame_available=0 the cycle after reset.
REQ-027 Reset mid-frame or with full banks SHALL discard all frames; RAM contents are not cleared.

Configuration
REQ-028 Macro DIGIT_FRAME_BUFFER_FRAME_COUNT_EN defined: adds output frames_done (16 bits), +1 per release (REQ-021), wrapping 16'hFFFF->0, cleared by reset.
REQ-029 Macro undefined: frames_done port and counter are absent; all other behaviour identical.

Verification
REQ-030 Stream 784 pixels (value = addr[7:0]), pix_last on 784th -> frame_available=1 next cycle; read address 5 -> read_data_a=16'h0005 one cycle later.
REQ-031 Stream 3 frames without release -> pix_ready=0 after 2nd frame commit, first pixel of 3rd frame stalls; write_data=0 release -> pix_ready=1 next cycle, full_cnt=1.
REQ-032 pix_last at pixel 100 -> frame_err=1, frame_available stays 0; next correct 784-pixel frame commits normally, frame_err stays 1.
REQ-033 Last pixel of frame 2 accepted in same cycle as release of frame 1 -> full_cnt stays 1, rd_bank reads frame 2 data.
REQ-034 write_en with write_data=8'h01, and release while empty -> no state change; address_a=800 -> read_data_a=0.
REQ-035 Assert reset with 1 frame full and 400 pixels of next -> frame_available=0, pix_ready=1; with DIGIT_FRAME_BUFFER_FRAME_COUNT_EN, frames_done=0.
